// File: rtl/mc_pricing_pkg.sv
// Shared types for the Monte-Carlo pricer: FSM states, payoff mode encoding
// and the lane-index width helper used by the dispatcher and reducer.
package mc_pricing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REDUCE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic MODE_CALL = 1'b0;
    localparam logic MODE_PUT  = 1'b1;

    // A single lane still needs a 1-bit index so every select stays legal.
    function automatic int lane_idx_w(input int n_lanes);
        return (n_lanes > 1) ? $clog2(n_lanes) : 1;
    endfunction

endpackage

// File: rtl/mc_payoff_lane.sv
// One payoff/accumulate lane: combinational call/put payoff feeding a
// registered accumulator with synchronous clear and per-sample enable.
module mc_payoff_lane
    import mc_pricing_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int ACC_W  = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] strike_i,
    input  logic [DATA_W-1:0] s_i,
    output logic [ACC_W-1:0]  acc_o
);

    logic [DATA_W-1:0] payoff;
    logic [ACC_W-1:0]  acc_q;

    always_comb begin
        payoff = '0;
        if (mode_i == MODE_PUT) begin
            if (strike_i > s_i) payoff = strike_i - s_i;
        end else begin
            if (s_i > strike_i) payoff = s_i - strike_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        acc_q <= '0;
        else if (clr_i) acc_q <= '0;
        else if (en_i)  acc_q <= acc_q + ACC_W'(payoff);
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mc_pricing_array.sv
// Monte-Carlo pricer: round-robin dispatch of path samples to N_LANES payoff
// lanes, serial lane reduction, then a held mean-payoff result until accepted.
module mc_pricing_array
    import mc_pricing_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int N_LANES    = 4,
    parameter int LOG2_PATHS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_put,
    input  logic [DATA_W-1:0] strike,
    input  logic              path_valid,
    input  logic [DATA_W-1:0] path_data,
    output logic              path_ready,
    output logic              price_valid,
    output logic [DATA_W-1:0] price,
    input  logic              price_ready,
    output logic              busy
);

    localparam int LW    = lane_idx_w(N_LANES);
    localparam int RW    = LW + 1;
    localparam int ACC_W = DATA_W + LOG2_PATHS;

    state_t                state_q;
    logic [LOG2_PATHS-1:0] cnt_q;
    logic [RW-1:0]         red_q;
    logic [ACC_W-1:0]      total_q;
    logic [DATA_W-1:0]     price_q;
    logic [DATA_W-1:0]     strike_q;
    logic                  mode_q;
    logic                  path_ready_q;
    logic                  price_valid_q;
    logic                  busy_q;

    logic                  hs;
    logic                  clr;
    logic [LW-1:0]         lane_sel;
    logic [ACC_W-1:0]      acc [N_LANES];
    logic [ACC_W-1:0]      red_sel;

    assign hs       = path_valid & path_ready_q;
    assign clr      = (state_q == ST_IDLE) & start;
    assign lane_sel = (N_LANES == 1) ? '0 : cnt_q[LW-1:0];

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        mc_payoff_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr_i    (clr),
            .en_i     (hs && (lane_sel == LW'(g))),
            .mode_i   (mode_q),
            .strike_i (strike_q),
            .s_i      (path_data),
            .acc_o    (acc[g])
        );
    end

    always_comb begin
        red_sel = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (red_q == RW'(i)) red_sel = acc[i];
        end
    end

    // red_q runs 0..N_LANES-1 adding lanes, then one extra cycle registers the mean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            red_q         <= '0;
            total_q       <= '0;
            price_q       <= '0;
            strike_q      <= '0;
            mode_q        <= MODE_CALL;
            path_ready_q  <= 1'b0;
            price_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        strike_q     <= strike;
                        mode_q       <= is_put;
                        cnt_q        <= '0;
                        total_q      <= '0;
                        path_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == '1) begin
                            path_ready_q <= 1'b0;
                            red_q        <= '0;
                            state_q      <= ST_REDUCE;
                        end
                    end
                end
                ST_REDUCE: begin
                    if (red_q == RW'(N_LANES)) begin
                        price_q       <= DATA_W'(total_q >> LOG2_PATHS);
                        price_valid_q <= 1'b1;
                        state_q       <= ST_DONE;
                    end else begin
                        total_q <= total_q + red_sel;
                        red_q   <= red_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (price_ready) begin
                        price_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign path_ready  = path_ready_q;
    assign price_valid = price_valid_q;
    assign price       = price_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mc_pricing_array.sv
// Three pricers (4, 1 and 8 lanes) driven by one shared stream; a scoreboard
// queue of expected prices is drained independently by a per-instance monitor.
module tb_mc_pricing_array;

    localparam int NL [3] = '{4, 1, 8};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_put = 1'b0;
    logic [11:0] strike = '0;
    logic        path_valid = 1'b0;
    logic [11:0] path_data = '0;
    logic        price_ready = 1'b1;
    logic [2:0]  pr;
    logic [2:0]  pv;
    logic [2:0]  bz;
    logic [11:0] pz [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int exp_q[$];
    int rd_idx [3] = '{0, 0, 0};
    logic [2:0]  pv_prev = '0;
    logic        rdy_prev = 1'b1;
    logic [11:0] held [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mc_pricing_array #(
            .DATA_W     (12),
            .N_LANES    (NL[g]),
            .LOG2_PATHS (3)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start),
            .is_put      (is_put),
            .strike      (strike),
            .path_valid  (path_valid),
            .path_data   (path_data),
            .path_ready  (pr[g]),
            .price_valid (pv[g]),
            .price       (pz[g]),
            .price_ready (price_ready),
            .busy        (bz[g])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (pv[k] && !pv_prev[k])
                chk($sformatf("latency_n%0d", NL[k]), cyc - acc_cyc, NL[k] + 1);
            if (pv[k] && pv_prev[k] && !rdy_prev)
                chk($sformatf("price_stable_n%0d", NL[k]), int'(pz[k]), int'(held[k]));
            if (pv[k] && price_ready) begin
                if (rd_idx[k] < exp_q.size())
                    chk($sformatf("price_n%0d_run%0d", NL[k], rd_idx[k]), int'(pz[k]), exp_q[rd_idx[k]]);
                else
                    chk($sformatf("unexpected_result_n%0d", NL[k]), 1, 0);
                rd_idx[k]++;
            end
            held[k] = pz[k];
        end
        pv_prev  = pv;
        rdy_prev = price_ready;
    end

    task automatic do_start(input logic put, input logic [11:0] k);
        start  = 1'b1;
        is_put = put;
        strike = k;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic send_sample(input logic [11:0] s, input int gap);
        bit ok;
        ok = 0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        path_valid = 1'b1;
        path_data  = s;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (pr[0]) begin
                ok = 1;
                acc_cyc = cyc + 1;
            end
            @(posedge clk); #1;
        end
        path_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic run_stream(input logic put, input logic [11:0] k,
                              input logic [11:0] s [8], input int gap, input int expv);
        exp_q.push_back(expv);
        do_start(put, k);
        for (int i = 0; i < 8; i++) send_sample(s[i], (i == 0) ? 0 : gap);
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(posedge clk); #1;
            done = (rd_idx[0] == exp_q.size()) && (rd_idx[1] == exp_q.size()) &&
                   (rd_idx[2] == exp_q.size());
        end
        if (!done) chk({name, "_done_timeout"}, 0, 1);
        for (int k = 0; k < 3; k++) chk($sformatf("%s_idle_busy_n%0d", name, NL[k]), int'(bz[k]), 0);
    endtask

    logic [11:0] s1 [8] = '{12'd110, 12'd90, 12'd120, 12'd100, 12'd130, 12'd80, 12'd140, 12'd100};
    logic [11:0] s4 [8] = '{12'd4095, 12'd4095, 12'd4095, 12'd4095,
                            12'd4095, 12'd4095, 12'd4095, 12'd4095};

    initial begin
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_path_ready_n%0d", NL[k]), int'(pr[k]), 0);
            chk($sformatf("rst_price_valid_n%0d", NL[k]), int'(pv[k]), 0);
            chk($sformatf("rst_price_n%0d", NL[k]), int'(pz[k]), 0);
            chk($sformatf("rst_busy_n%0d", NL[k]), int'(bz[k]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // call K=100: payoffs 10,0,20,0,30,0,40,0 -> 100/8 = 12
        run_stream(1'b0, 12'd100, s1, 0, 12);
        wait_done("call");

        // put K=100: payoffs 0,10,0,0,0,20,0,0 -> 30/8 = 3
        run_stream(1'b1, 12'd100, s1, 0, 3);
        wait_done("put");

        // backpressure on both sides, plus a start pulse while results are held
        price_ready = 1'b0;
        run_stream(1'b0, 12'd100, s1, 3, 12);
        for (int t = 0; t < 100 && pv != 3'b111; t++) begin
            @(posedge clk); #1;
        end
        chk("bp_all_valid", int'(pv), 7);
        for (int t = 0; t < 6; t++) begin
            start  = (t == 2);
            is_put = 1'b1;
            strike = 12'd55;
            @(posedge clk); #1;
        end
        start = 1'b0;
        price_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("bp");
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("bp_no_rerun_n%0d", NL[k]), int'(bz[k]), 0);

        // K=0, full-scale S: sum 8*4095 must not wrap
        run_stream(1'b0, 12'd0, s4, 0, 4095);
        wait_done("ovf");

        // reset after three accepted samples aborts immediately
        do_start(1'b0, 12'd100);
        for (int i = 0; i < 3; i++) send_sample(s1[i], 0);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abort_busy_n%0d", NL[k]), int'(bz[k]), 0);
            chk($sformatf("abort_path_ready_n%0d", NL[k]), int'(pr[k]), 0);
            chk($sformatf("abort_price_valid_n%0d", NL[k]), int'(pv[k]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_stream(1'b0, 12'd100, s1, 0, 12);
        wait_done("rerun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mc_pricing_array.md
Name: mc_pricing_array

Overview:
Parametrised Monte-Carlo option pricer. It accepts a stream of simulated terminal prices, S, over a valid/ready handshake and distributes them round-robin across N_LANES payoff/accumulate lanes. After 2^LOG2_PATHS samples it reduces the lanes and outputs the mean payoff, truncated, with a valid/ready handshake. Call and put modes are supported. It sits between the path generator and the result readout.

Parameters:
DATA_W, 12, width of path samples, strike and price.
N_LANES, 4, number of payoff/accumulate lanes; power of 2, 1..16.
LOG2_PATHS, 10, log2 of samples per estimate; must be >= log2(N_LANES).

Ports:
clk  in  1  clock.
rst  in  1  reset. One clock; reset is asynchronous and active-high.
start  in  1  one-cycle pulse; begins an estimate. Ignored unless the FSM is in IDLE.
is_put  in  1  payoff mode, sampled at start: 0 = call, 1 = put.
strike  in  DATA_W  strike K, sampled at start.
path_valid  in  1  path sample valid.
path_data  in  DATA_W  simulated terminal price S, unsigned.
path_ready  out  1  high only in RUN.
price_valid  out  1  result valid; held until accepted.
price  out  DATA_W  mean payoff.
price_ready  in  1  consumer accepts the result.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: path_ready=0, price_valid=0, price=0, busy=0. All accumulators, the sample counter and the FSM (IDLE) are cleared.
- FSM states: IDLE, RUN, REDUCE, DONE.
- IDLE, on start:
  - latch strike and is_put;
  - clear the lane accumulators, the counter cnt and the total;
  - move to RUN next cycle.
- RUN:
  - path_ready=1.
  - A handshake is path_valid & path_ready in the same cycle.
  - On a handshake, lane = cnt[log2(N_LANES)-1:0].
  - Call payoff: S>K ? S-K : 0. Put payoff: K>S ? K-S : 0. Payoff width is DATA_W, unsigned.
  - acc[lane] += payoff, then cnt++.
  - A handshake at cnt = 2^LOG2_PATHS-1 moves to REDUCE. path_ready drops the following cycle, so exactly 2^LOG2_PATHS samples are accepted.
- Accumulator width is ACC_W = DATA_W+LOG2_PATHS, for both lanes and total. This width cannot overflow.
- REDUCE:
  - adds one lane per cycle into total: lane 0 first, lane N_LANES-1 last;
  - takes N_LANES cycles, then goes to DONE;
  - registers price = total >> LOG2_PATHS (truncation).
- Latency: price_valid rises N_LANES+1 cycles after the clock edge that accepts the final sample.
- DONE:
  - price_valid=1; price is held stable;
  - on price_ready, go to IDLE; price_valid=0 next cycle;
  - price keeps its last value in IDLE.
- start is ignored in RUN, REDUCE and DONE. start asserted in the same cycle as the DONE handshake is also ignored.
- path_valid outside RUN is ignored; no sample is consumed.
- Gaps in path_valid stall the count; there is no timeout.
- Reset mid-operation aborts immediately and discards all partial state.
- The result is independent of N_LANES for identical input streams.

Decomposition:
- Shared package mc_pricing_pkg holds:
  - the FSM state enum;
  - the mode encoding (MODE_CALL=0, MODE_PUT=1);
  - a function computing the lane-index width from N_LANES.
- One sub-module, mc_payoff_lane: combinational payoff plus a registered accumulator, with clear and enable inputs. It is instantiated N_LANES times in a generate loop.
- The dispatcher, the reduce logic and the FSM stay in the top module.

Test Plan:
1. LOG2_PATHS=3, N_LANES=4, call, K=100, S=110,90,120,100,130,80,140,100 -> payoffs sum to 100, price=12 (12.5 truncated). price_valid rises 5 cycles after the last accept.
2. Same stream, put mode -> payoffs 0,10,0,0,0,20,0,0, price=3.
3. Backpressure on test 1:
   - path_valid low for 3 cycles between samples;
   - price_ready low for 6 cycles in DONE;
   - start pulsed during DONE;
   -> price stays 12 and stable; no new run begins; IDLE is reached after the accept.
4. Overflow bound: LOG2_PATHS=3, call, K=0, all S=4095 -> price=4095, no wrap.
5. Reset mid-RUN after 3 samples accepted:
   - busy, path_ready and price_valid go to 0 immediately;
   - then rerun test 1 -> price=12.
6. Lane invariance: rerun test 1 with N_LANES=1 and with N_LANES=8 -> price=12 in both. REDUCE takes 1 and 8 cycles respectively.
